// File: rtl/abc_sample_conditioner.sv
// Three-phase ADC front-end: per-channel offset removal with optional averaging calibration,
// Clarke alpha/beta transform, and a one-cycle o_ce strobe three edges after each valid sample.
module abc_sample_conditioner #(
  parameter int IN_DATA_WIDTH  = 12,
  parameter int OUT_WIDTH      = 16,
  parameter int LG_CAL_SAMPLES = 8,
  parameter int MID_CODE       = 2047
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        i_valid,
  input  logic [IN_DATA_WIDTH-1:0]    phase_a,
  input  logic [IN_DATA_WIDTH-1:0]    phase_b,
  input  logic [IN_DATA_WIDTH-1:0]    phase_c,
  input  logic                        i_cal_start,
  output logic                        o_ce,
  output logic signed [OUT_WIDTH-1:0] o_a,
  output logic signed [OUT_WIDTH-1:0] o_b,
  output logic signed [OUT_WIDTH-1:0] o_c,
  output logic signed [OUT_WIDTH-1:0] o_alpha,
  output logic signed [OUT_WIDTH-1:0] o_beta,
  output logic                        o_cal_busy,
  output logic                        o_cal_done
);

  localparam int SW    = IN_DATA_WIDTH + 1;
  localparam int SUM_W = SW + 3;
  localparam int DIF_W = SW + 1;
  localparam int ACC_W = IN_DATA_WIDTH + LG_CAL_SAMPLES;

  localparam logic [ACC_W:0]              ROUND   = (ACC_W+1)'(2**(LG_CAL_SAMPLES-1));
  localparam logic [IN_DATA_WIDTH-1:0]    MID     = IN_DATA_WIDTH'(MID_CODE);
  localparam logic [LG_CAL_SAMPLES-1:0]   CNT_ONE = LG_CAL_SAMPLES'(1);
  localparam logic signed [31:0]          ALPHA_K = 32'sd10923;
  localparam logic signed [31:0]          BETA_K  = 32'sd18919;
  localparam logic signed [31:0]          SAT_MAX = 2**(OUT_WIDTH-1) - 1;
  localparam logic signed [31:0]          SAT_MIN = -(2**(OUT_WIDTH-1));

  typedef enum logic {RUN, CAL} state_t;

  state_t                      state;
  logic                        cal_next;
  logic [LG_CAL_SAMPLES-1:0]   cnt;
  logic [ACC_W-1:0]            acc_a, acc_b, acc_c;
  logic [IN_DATA_WIDTH-1:0]    off_a, off_b, off_c;

  logic                        cap_v;
  logic [IN_DATA_WIDTH-1:0]    cap_a, cap_b, cap_c;
  logic signed [SW-1:0]        a_s, b_s, c_s;
  logic signed [SUM_W-1:0]     sum2;
  logic signed [DIF_W-1:0]     dif;

  logic                        s1_v;
  logic signed [SW-1:0]        s1_a, s1_b, s1_c;
  logic signed [SUM_W-1:0]     s1_sum2;
  logic signed [DIF_W-1:0]     s1_dif;

  // Rounded mean including the sample that completes the window.
  function automatic logic [IN_DATA_WIDTH-1:0] avg(input logic [ACC_W-1:0] acc,
                                                   input logic [IN_DATA_WIDTH-1:0] code);
    logic [ACC_W:0] s;
    s = {1'b0, acc} + (ACC_W+1)'(code) + ROUND;
    return IN_DATA_WIDTH'(s >> LG_CAL_SAMPLES);
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] sat(input logic signed [31:0] v);
    if (v > SAT_MAX)      return OUT_WIDTH'(SAT_MAX);
    else if (v < SAT_MIN) return OUT_WIDTH'(SAT_MIN);
    else                  return OUT_WIDTH'(v);
  endfunction

  // State the FSM will be in after this edge; used to suppress o_ce while busy.
  always_comb begin
    cal_next = i_cal_start || ((state == CAL) && !(i_valid && (&cnt)));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state      <= RUN;
      cnt        <= '0;
      acc_a      <= '0;
      acc_b      <= '0;
      acc_c      <= '0;
      off_a      <= MID;
      off_b      <= MID;
      off_c      <= MID;
      o_cal_busy <= 1'b0;
      o_cal_done <= 1'b0;
    end else begin
      o_cal_done <= 1'b0;
      if (i_cal_start) begin
        state      <= CAL;
        o_cal_busy <= 1'b1;
        cnt        <= '0;
        acc_a      <= '0;
        acc_b      <= '0;
        acc_c      <= '0;
      end else if (state == CAL && i_valid) begin
        if (&cnt) begin
          off_a      <= avg(acc_a, phase_a);
          off_b      <= avg(acc_b, phase_b);
          off_c      <= avg(acc_c, phase_c);
          cnt        <= '0;
          state      <= RUN;
          o_cal_busy <= 1'b0;
          o_cal_done <= 1'b1;
        end else begin
          acc_a <= acc_a + ACC_W'(phase_a);
          acc_b <= acc_b + ACC_W'(phase_b);
          acc_c <= acc_c + ACC_W'(phase_c);
          cnt   <= cnt + CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    a_s  = $signed({1'b0, cap_a}) - $signed({1'b0, off_a});
    b_s  = $signed({1'b0, cap_b}) - $signed({1'b0, off_b});
    c_s  = $signed({1'b0, cap_c}) - $signed({1'b0, off_c});
    sum2 = (SUM_W'(a_s) <<< 1) - SUM_W'(b_s) - SUM_W'(c_s);
    dif  = DIF_W'(b_s) - DIF_W'(c_s);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      cap_v   <= 1'b0;
      cap_a   <= '0;
      cap_b   <= '0;
      cap_c   <= '0;
      s1_v    <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_c    <= '0;
      s1_sum2 <= '0;
      s1_dif  <= '0;
      o_ce    <= 1'b0;
      o_a     <= '0;
      o_b     <= '0;
      o_c     <= '0;
      o_alpha <= '0;
      o_beta  <= '0;
    end else begin
      cap_v <= i_valid;
      if (i_valid) begin
        cap_a <= phase_a;
        cap_b <= phase_b;
        cap_c <= phase_c;
      end
      s1_v <= cap_v;
      if (cap_v) begin
        s1_a    <= a_s;
        s1_b    <= b_s;
        s1_c    <= c_s;
        s1_sum2 <= sum2;
        s1_dif  <= dif;
      end
      o_ce <= s1_v && !cal_next;
      if (s1_v) begin
        o_a     <= sat(32'(s1_a));
        o_b     <= sat(32'(s1_b));
        o_c     <= sat(32'(s1_c));
        o_alpha <= sat((32'(s1_sum2) * ALPHA_K) >>> 15);
        o_beta  <= sat((32'(s1_dif) * BETA_K) >>> 15);
      end
    end
  end

endmodule

// File: tb/tb_abc_sample_conditioner.sv
// Directed bench for abc_sample_conditioner: reset, offset removal, Clarke math, pipeline timing
// and the calibration sequencing (normal, aborted by reset, restarted).
module tb_abc_sample_conditioner;

  logic               clk;
  logic               rstn;
  logic               valid;
  logic [11:0]        pa, pb, pc;
  logic               cal_start;
  logic               ce;
  logic signed [15:0] oa, ob, oc, oalpha, obeta;
  logic               busy;
  logic               done;

  int checks = 0;
  int errors = 0;

  abc_sample_conditioner dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_valid     (valid),
    .phase_a     (pa),
    .phase_b     (pb),
    .phase_c     (pc),
    .i_cal_start (cal_start),
    .o_ce        (ce),
    .o_a         (oa),
    .o_b         (ob),
    .o_c         (oc),
    .o_alpha     (oalpha),
    .o_beta      (obeta),
    .o_cal_busy  (busy),
    .o_cal_done  (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one valid sample right after a negedge and returns at the negedge where it shows up.
  task automatic send_one(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
    pa = a; pb = b; pc = c;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; valid = 1'b1; cal_start = 1'b1;
    pa = 12'd4095; pb = 12'd0; pc = 12'd0;
    repeat (3) @(negedge clk);
    checks++; if (ce !== 1'b0) begin errors++; $display("FAIL reset_ce got %0b want 0", ce); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++;
    if (oa !== 0 || ob !== 0 || oc !== 0 || oalpha !== 0 || obeta !== 0) begin
      errors++;
      $display("FAIL reset_outs got %0d %0d %0d %0d %0d want all 0", oa, ob, oc, oalpha, obeta);
    end
    cal_start = 1'b0;
    pa = 12'd4095; pb = 12'd2047; pc = 12'd2047;
    rstn = 1'b1; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    checks++; if (ce !== 1'b0) begin errors++; $display("FAIL first_lat1 got ce=%0b want 0", ce); end
    @(negedge clk);
    checks++; if (ce !== 1'b0) begin errors++; $display("FAIL first_lat2 got ce=%0b want 0", ce); end
    @(negedge clk);
    checks++; if (ce !== 1'b1) begin errors++; $display("FAIL first_lat3 got ce=%0b want 1", ce); end
    checks++; if (oa !== 2048) begin errors++; $display("FAIL clarke1_a got %0d want 2048", oa); end
    checks++; if (oalpha !== 1365) begin errors++; $display("FAIL clarke1_alpha got %0d want 1365", oalpha); end
    checks++; if (obeta !== 0) begin errors++; $display("FAIL clarke1_beta got %0d want 0", obeta); end
    @(negedge clk);
    checks++; if (ce !== 1'b0) begin errors++; $display("FAIL ce_one_cycle got %0b want 0", ce); end
  endtask

  task automatic test_clarke();
    // sum2 = 0 - 2048 + 2047 = -1; floor(-10923/32768) = -1.
    send_one(12'd2047, 12'd4095, 12'd0);
    checks++; if (ce !== 1'b1) begin errors++; $display("FAIL clarke2_ce got %0b want 1", ce); end
    checks++; if (ob !== 2048) begin errors++; $display("FAIL clarke2_b got %0d want 2048", ob); end
    checks++; if (oc !== -2047) begin errors++; $display("FAIL clarke2_c got %0d want -2047", oc); end
    checks++; if (oalpha !== -1) begin errors++; $display("FAIL clarke2_alpha got %0d want -1", oalpha); end
    checks++; if (obeta !== 2364) begin errors++; $display("FAIL clarke2_beta got %0d want 2364", obeta); end
    // sum2 = -8190 -> floor(-89459370/32768) = -2731.
    send_one(12'd0, 12'd4095, 12'd4095);
    checks++; if (oa !== -2047) begin errors++; $display("FAIL clarke3_a got %0d want -2047", oa); end
    checks++; if (oalpha !== -2731) begin errors++; $display("FAIL clarke3_alpha got %0d want -2731", oalpha); end
    checks++; if (obeta !== 0) begin errors++; $display("FAIL clarke3_beta got %0d want 0", obeta); end
  endtask

  task automatic test_midcode();
    send_one(12'd2047, 12'd2047, 12'd2047);
    checks++; if (ce !== 1'b1) begin errors++; $display("FAIL mid_ce got %0b want 1", ce); end
    checks++;
    if (oa !== 0 || ob !== 0 || oc !== 0 || oalpha !== 0 || obeta !== 0) begin
      errors++;
      $display("FAIL mid_outs got %0d %0d %0d %0d %0d want all 0", oa, ob, oc, oalpha, obeta);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    valid = 1'b1;
    pa = 12'd4095; pb = 12'd2047; pc = 12'd2047; @(negedge clk);
    pa = 12'd2047; pb = 12'd2047; pc = 12'd2047; @(negedge clk);
    pa = 12'd2047; pb = 12'd4095; pc = 12'd0;    @(negedge clk);
    valid = 1'b0;
    checks++;
    if (ce !== 1'b1 || oa !== 2048 || oalpha !== 1365) begin
      errors++; $display("FAIL b2b_0 got ce=%0b a=%0d alpha=%0d want 1 2048 1365", ce, oa, oalpha);
    end
    @(negedge clk);
    checks++;
    if (ce !== 1'b1 || oa !== 0 || oalpha !== 0) begin
      errors++; $display("FAIL b2b_1 got ce=%0b a=%0d alpha=%0d want 1 0 0", ce, oa, oalpha);
    end
    @(negedge clk);
    checks++;
    if (ce !== 1'b1 || oc !== -2047 || obeta !== 2364) begin
      errors++; $display("FAIL b2b_2 got ce=%0b c=%0d beta=%0d want 1 -2047 2364", ce, oc, obeta);
    end
    @(negedge clk);
    checks++;
    if (ce !== 1'b0 || obeta !== 2364 || oalpha !== -1) begin
      errors++; $display("FAIL b2b_hold got ce=%0b beta=%0d alpha=%0d want 0 2364 -1", ce, obeta, oalpha);
    end
  endtask

  task automatic test_reset_mid_cal();
    int ce_bad;
    int done_cnt;
    ce_bad = 0; done_cnt = 0;
    cal_start = 1'b1; @(negedge clk); cal_start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rcal_busy got %0b want 1", busy); end
    pa = 12'd2100; pb = 12'd2000; pc = 12'd2047;
    valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ce) ce_bad++;
    end
    rstn = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rcal_busy_rst got %0b want 0", busy); end
    checks++; if (oa !== 0 || ce !== 1'b0) begin errors++; $display("FAIL rcal_out_rst got a=%0d ce=%0b want 0 0", oa, ce); end
    rstn = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ce_bad !== 0) begin errors++; $display("FAIL rcal_ce_in_cal got %0d strobes want 0", ce_bad); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL rcal_done got %0d pulses want 0", done_cnt); end
    // Offsets back at 2047: a=53, b=-47, alpha=floor(153*10923/32768)=51, beta=floor(-47*18919/32768)=-28.
    send_one(12'd2100, 12'd2000, 12'd2047);
    checks++;
    if (oa !== 53 || ob !== -47 || oc !== 0) begin
      errors++; $display("FAIL rcal_offsets got %0d %0d %0d want 53 -47 0", oa, ob, oc);
    end
    checks++;
    if (oalpha !== 51 || obeta !== -28) begin
      errors++; $display("FAIL rcal_clarke got %0d %0d want 51 -28", oalpha, obeta);
    end
  endtask

  task automatic test_calibration();
    int n;
    int ce_bad;
    int state_bad;
    logic v;
    n = 0; ce_bad = 0; state_bad = 0;
    @(negedge clk);
    cal_start = 1'b1; @(negedge clk); cal_start = 1'b0;
    pa = 12'd2100; pb = 12'd2000; pc = 12'd2047;
    for (int cyc = 0; cyc < 3000 && n < 256; cyc++) begin
      v = ($urandom_range(0, 3) != 0);
      valid = v;
      @(negedge clk);
      if (v) n++;
      if (busy && ce) ce_bad++;
      if (n < 256 && (busy !== 1'b1 || done !== 1'b0)) state_bad++;
    end
    valid = 1'b0;
    checks++; if (n !== 256) begin errors++; $display("FAIL cal_timeout got %0d valids want 256", n); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL cal_done got %0b want 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cal_busy_end got %0b want 0", busy); end
    checks++; if (ce_bad !== 0) begin errors++; $display("FAIL cal_ce_in_cal got %0d want 0", ce_bad); end
    checks++; if (state_bad !== 0) begin errors++; $display("FAIL cal_busy_hold got %0d bad cycles want 0", state_bad); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL cal_done_width got %0b want 0", done); end
    repeat (3) @(negedge clk);
    send_one(12'd2100, 12'd2000, 12'd2047);
    checks++;
    if (ce !== 1'b1 || oa !== 0 || ob !== 0 || oc !== 0 || oalpha !== 0 || obeta !== 0) begin
      errors++;
      $display("FAIL cal_zero got ce=%0b %0d %0d %0d %0d %0d want 1 and all 0", ce, oa, ob, oc, oalpha, obeta);
    end
  endtask

  task automatic test_restart();
    int n;
    int early;
    logic v;
    n = 0; early = 0;
    @(negedge clk);
    cal_start = 1'b1; @(negedge clk); cal_start = 1'b0;
    pa = 12'd4000; pb = 12'd100; pc = 12'd4000;
    valid = 1'b1;
    repeat (50) @(negedge clk);
    valid = 1'b0; cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got %0b want 1", busy); end
    pa = 12'd1000; pb = 12'd3000; pc = 12'd2047;
    for (int cyc = 0; cyc < 3000 && n < 256; cyc++) begin
      v = ($urandom_range(0, 2) != 0);
      valid = v;
      @(negedge clk);
      if (v) n++;
      if (n < 256 && done) early++;
    end
    valid = 1'b0;
    checks++; if (early !== 0) begin errors++; $display("FAIL restart_early got %0d pulses want 0", early); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL restart_done got %0b want 1", done); end
    repeat (3) @(negedge clk);
    // New offsets 1000/3000/2047: a=10, sum2=20 -> alpha=floor(218460/32768)=6.
    send_one(12'd1010, 12'd3000, 12'd2047);
    checks++;
    if (oa !== 10 || ob !== 0 || oc !== 0 || oalpha !== 6 || obeta !== 0) begin
      errors++;
      $display("FAIL restart_offsets got %0d %0d %0d %0d %0d want 10 0 0 6 0", oa, ob, oc, oalpha, obeta);
    end
  endtask

  initial begin
    rstn = 1'b0; valid = 1'b0; cal_start = 1'b0;
    pa = '0; pb = '0; pc = '0;
    @(negedge clk);
    test_reset();
    test_clarke();
    test_midcode();
    test_back_to_back();
    test_reset_mid_cal();
    test_calibration();
    test_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
